// File: rtl/uart_pkg.sv
// Shared UART definitions: frame state encoding, data width and default line timing.
package uart_pkg;

  localparam int unsigned DATA_BITS    = 8;
  localparam int unsigned DEF_CLK_FREQ = 50_000_000;
  localparam int unsigned DEF_BAUD     = 9600;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period counter: bit_tick pulses on the last cycle of each BIT_DIV-cycle period.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned BIT_DIV = DEF_CLK_FREQ / DEF_BAUD
) (
  input  logic sclk,
  input  logic reset,
  input  logic clear,
  output logic bit_tick
);

  localparam int unsigned CNT_W = ($clog2(BIT_DIV) > 13) ? $clog2(BIT_DIV) : 13;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BIT_DIV - 1);

  logic [CNT_W-1:0] count;

  assign bit_tick = (count == LAST);

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || bit_tick) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 by default; define UART_TX_PARITY_EN to insert an even-parity bit.
module uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = DEF_CLK_FREQ,
  parameter int unsigned BAUD     = DEF_BAUD
) (
  input  logic       sclk,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_trig,
  output logic       RS232_tx
);

  localparam int unsigned BIT_DIV = CLK_FREQ / BAUD;
  localparam int unsigned IDX_W   = $clog2(DATA_BITS);

  state_t                 state, state_next;
  logic [DATA_BITS-1:0]   shreg;
  logic [IDX_W-1:0]       bit_idx;
  logic                   bit_tick;
  logic                   start_frame;
  logic                   tx_next;

  uart_baud_gen #(
    .BIT_DIV(BIT_DIV)
  ) u_baud_gen (
    .sclk    (sclk),
    .reset   (reset),
    .clear   (start_frame),
    .bit_tick(bit_tick)
  );

  always_comb begin
    state_next  = state;
    start_frame = 1'b0;
    tx_next     = 1'b1;
    case (state)
      IDLE: begin
        if (tx_trig) begin
          start_frame = 1'b1;
          state_next  = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (bit_tick) state_next = DATA;
      end
      DATA: begin
        tx_next = shreg[0];
        if (bit_tick && (bit_idx == IDX_W'(DATA_BITS - 1))) begin
`ifdef UART_TX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      // The shift register rotates, so after eight bits it holds the latched byte again.
      PARITY: begin
        tx_next = ^shreg;
        if (bit_tick) state_next = STOP;
      end
`endif
      STOP: begin
        if (bit_tick) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge sclk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      RS232_tx <= 1'b1;
      shreg    <= '0;
      bit_idx  <= '0;
    end else begin
      state    <= state_next;
      RS232_tx <= tx_next;
      if (start_frame) begin
        shreg   <= tx_data;
        bit_idx <= '0;
      end else if ((state == DATA) && bit_tick) begin
        shreg   <= {shreg[0], shreg[DATA_BITS-1:1]};
        bit_idx <= bit_idx + IDX_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at a short bit period (1000/60 truncates to 16 cycles per bit).
module tb_uart_tx;

  localparam int BD = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
  localparam logic [10:0] F_C3 = 11'b0_11000011_0_1;
  localparam logic [10:0] F_A4 = 11'b0_00100101_1_1;
  localparam logic [10:0] F_0F = 11'b0_11110000_0_1;
`else
  localparam int NB = 10;
  localparam logic [10:0] F_C3 = 11'b0_0_11000011_1;
  localparam logic [10:0] F_A4 = 11'b0_0_00100101_1;
  localparam logic [10:0] F_0F = 11'b0_0_11110000_1;
`endif

  logic       sclk;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_trig;
  logic       RS232_tx;

  int total;
  int bad;

  uart_tx #(
    .CLK_FREQ(1000),
    .BAUD    (60)
  ) dut (
    .sclk    (sclk),
    .reset   (reset),
    .tx_data (tx_data),
    .tx_trig (tx_trig),
    .RS232_tx(RS232_tx)
  );

  initial begin
    sclk = 1'b0;
    forever #10 sclk = ~sclk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic idle_for(input int n, input string tag);
    logic high;
    high = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      if (RS232_tx !== 1'b1) high = 1'b0;
    end
    check(tag, {31'd0, high}, 32'd1);
  endtask

  // Trigger a frame and compare the line at the first, middle and last cycle of every bit.
  task automatic run_frame(input logic [7:0] d, input logic [10:0] exp, input int hold,
                           input bit inject, input int stop_at, input string tag);
    int bi;
    int pos;
    tx_data = d;
    tx_trig = 1'b1;
    tick();
    check({tag, "_lat"}, {31'd0, RS232_tx}, 32'd1);
    tx_data = ~d;
    if (hold <= 1) tx_trig = 1'b0;
    for (int c = 0; c < stop_at; c++) begin
      tick();
      if (c + 2 == hold) tx_trig = 1'b0;
      if (inject && c == 3 * BD) begin
        tx_trig = 1'b1;
        tx_data = 8'h55;
      end
      if (inject && c == 3 * BD + 2) tx_trig = 1'b0;
      bi  = c / BD;
      pos = c % BD;
      if (pos == 0 || pos == BD / 2 || pos == BD - 1)
        check($sformatf("%s_b%0d_p%0d", tag, bi, pos), {31'd0, RS232_tx},
              {31'd0, exp[NB-1-bi]});
    end
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    reset   = 1'b0;
    tx_trig = 1'b0;
    tx_data = 8'h00;

    while ($time < 190) begin
      @(negedge sclk);
      check("rst_line", {31'd0, RS232_tx}, 32'd1);
    end
    #1 reset = 1'b1;
    idle_for(8, "idle0");

    run_frame(8'hC3, F_C3, 1, 1'b1, NB * BD, "c3");
    idle_for(3 * BD, "no55");

    idle_for(40, "gap");
    run_frame(8'hA4, F_A4, 1, 1'b0, NB * BD, "a4");
    run_frame(8'h0F, F_0F, 1, 1'b0, NB * BD, "b2b");
    idle_for(2 * BD, "idle1");

    run_frame(8'hC3, F_C3, 1, 1'b0, 5 * BD + BD / 2 + 1, "abort");
    #4 reset = 1'b0;
    #1 check("rst_async", {31'd0, RS232_tx}, 32'd1);
    tx_data = 8'h0F;
    tx_trig = 1'b1;
    tick();
    tick();
    check("rst_hold", {31'd0, RS232_tx}, 32'd1);
    #5 reset = 1'b1;
    run_frame(8'h0F, F_0F, 5, 1'b0, NB * BD, "f0f");
    idle_for(3 * BD, "one_shot");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
